// File: rtl/cpu_if_prefetch.sv
// rtl/cpu_if_prefetch.sv - instruction fetch stage with prefetch queue and branch bubbles
module cpu_if_prefetch #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 4,
  parameter int              BR_BUBBLES = 3,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] NOP_INSN   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc_if,
  output logic [XLEN-1:0] ir,
  output logic            ir_valid
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] ONE     = 1;

  typedef enum logic {RUN, BR_WAIT} state_t;

  state_t          state;
  logic [2:0]      bubble_cnt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [XLEN-1:0] q_insn [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            inflight;
  logic [XLEN-1:0] inflight_addr;
  logic            dropped;

  logic [CW:0]     occupancy;
  logic            pop;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_insn;
  logic            is_branch;
  logic            push;
  logic            bubble_step;
  logic            last_bubble;

  // A request is only issued when the queue has a free slot for its response,
  // counting the one already in flight, so a push can never overflow.
  assign occupancy   = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_req    = en && (state == RUN) && (occupancy < DEPTH_C);
  assign imem_addr   = fetch_pc;

  assign pop         = en && !stall && (state == RUN) && (count != '0);
  assign head_pc     = q_pc[rd_ptr];
  assign head_insn   = q_insn[rd_ptr];
  assign is_branch   = pop && ((head_insn[XLEN-1:XLEN-4] == 4'b0100) ||
                               (head_insn[XLEN-1:XLEN-4] == 4'b0101));
  // Responses are captured even with en low; a flush on the same edge wins.
  assign push        = imem_rvalid && inflight && !dropped && !is_branch;
  assign bubble_step = en && !stall && (state == BR_WAIT);
  assign last_bubble = bubble_step && (bubble_cnt == 3'd1);

  // Queue storage: written at the tail with the response and its request address.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= inflight_addr;
      q_insn[wr_ptr] <= imem_rdata;
    end
  end

  // Queue pointers and occupancy; a taken branch/jump discards everything queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (is_branch) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Fetch address and in-flight tracking; the response to a request issued on
  // the branch edge is marked dropped so it never enters the flushed queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc      <= RESET_PC;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      dropped       <= 1'b0;
    end else begin
      if (imem_req)         inflight <= 1'b1;
      else if (imem_rvalid) inflight <= 1'b0;

      if (imem_req) inflight_addr <= fetch_pc;

      if (is_branch)        dropped <= imem_req;
      else if (imem_rvalid) dropped <= 1'b0;

      if (is_branch)                          fetch_pc <= head_pc + ONE;
      else if (last_bubble && redirect_valid) fetch_pc <= redirect_pc;
      else if (imem_req)                      fetch_pc <= fetch_pc + ONE;
    end
  end

  // Output stage and RUN/BR_WAIT sequencing; the branch itself is presented,
  // then BR_BUBBLES enabled cycles of NOP follow before fetching resumes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      bubble_cnt <= '0;
      pc_if      <= RESET_PC;
      ir         <= NOP_INSN;
      ir_valid   <= 1'b0;
    end else begin
      if (pop) begin
        pc_if    <= head_pc;
        ir       <= head_insn;
        ir_valid <= 1'b1;
      end else if (en && !stall) begin
        ir       <= NOP_INSN;
        ir_valid <= 1'b0;
      end

      case (state)
        RUN: begin
          if (is_branch) begin
            state      <= BR_WAIT;
            bubble_cnt <= 3'(BR_BUBBLES);
          end
        end
        BR_WAIT: begin
          if (bubble_step) begin
            bubble_cnt <= bubble_cnt - 3'd1;
            if (bubble_cnt == 3'd1) state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
